// File: rtl/datapath_pkg.sv
// ---------------------------------------------------------------------------
// datapath_pkg
// Shared constants and types for the single-bus CPU datapath.
//   WORD_W      : data path width (32)
//   SHAMT_W     : width of the shift-amount field taken from the bus (5)
//   bus_src_e   : bus source selection, listed in priority order
//   alu_op_e    : ALU operation (pass, increment, arithmetic shift right)
//   sext_c      : sign-extends the 19-bit IR constant field to a full word
// ---------------------------------------------------------------------------
package datapath_pkg;

  localparam int WORD_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int CONST_W = 19;

  // Highest priority first; SRC_NONE means nothing drives the bus.
  typedef enum logic [3:0] {
    SRC_NONE   = 4'd0,
    SRC_PC     = 4'd1,
    SRC_MDR    = 4'd2,
    SRC_ZLO    = 4'd3,
    SRC_ZHI    = 4'd4,
    SRC_HI     = 4'd5,
    SRC_LO     = 4'd6,
    SRC_INPORT = 4'd7,
    SRC_C      = 4'd8,
    SRC_R2     = 4'd9,
    SRC_R3     = 4'd10,
    SRC_R4     = 4'd11,
    SRC_R5     = 4'd12,
    SRC_R7     = 4'd13
  } bus_src_e;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_INC  = 2'd1,
    OP_SHRA = 2'd2
  } alu_op_e;

  function automatic logic [WORD_W-1:0] sext_c(input logic [CONST_W-1:0] c);
    return {{(WORD_W-CONST_W){c[CONST_W-1]}}, c};
  endfunction

endpackage

// File: rtl/reg32.sv
// ---------------------------------------------------------------------------
// reg32
// 32-bit storage register. Captures on the falling edge of the clock when
// enabled; cleared asynchronously by an active-low clear.
//   i_clk   : clock (capture on falling edge)
//   i_clr_n : asynchronous active-low clear
//   i_en    : load enable
//   i_d     : data in
//   o_q     : stored value
// ---------------------------------------------------------------------------
module reg32
  import datapath_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_clr_n,
  input  logic              i_en,
  input  logic [WORD_W-1:0] i_d,
  output logic [WORD_W-1:0] o_q
);

  logic [WORD_W-1:0] r_q;

  always_ff @(negedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/cpu_datapath.sv
// ---------------------------------------------------------------------------
// cpu_datapath
// 32-bit single-bus CPU datapath. An external control unit supplies one
// control word per clock; every register transfer goes over one shared bus
// and every register captures on the falling edge.
//
// Ports:
//   clk        : clock (registers capture on falling edge)
//   clr        : asynchronous active-low reset
//   MDatain    : memory read data
//   Read       : MDR input select (1 = MDatain, 0 = bus)
//   PCin..R3in : register load enables
//   PCout..R7out : bus source selects (fixed priority, PCout highest)
//   IncPC      : ALU op Z = bus + 1 (wins over SHRA)
//   SHRA       : ALU op Z = Y >>> bus[4:0]
//   BusMuxOut  : current bus value
//   MARout     : memory address register
//   IRout      : instruction register
//
// Optional feature (macro DATAPATH_INPORT_EN):
//   adds InPortData / InPortStrobe and an in-port register that InPortout
//   places on the bus. Without the macro InPortout drives 0.
// ---------------------------------------------------------------------------
module cpu_datapath
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic [WORD_W-1:0] MDatain,
  input  logic              Read,
  input  logic              PCin,
  input  logic              IRin,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Yin,
  input  logic              Zin,
  input  logic              R1in,
  input  logic              R2in,
  input  logic              R3in,
  input  logic              PCout,
  input  logic              MDRout,
  input  logic              Zlowout,
  input  logic              Zhighout,
  input  logic              HIout,
  input  logic              LOout,
  input  logic              InPortout,
  input  logic              Cout,
  input  logic              R2out,
  input  logic              R3out,
  input  logic              R4out,
  input  logic              R5out,
  input  logic              R7out,
  input  logic              IncPC,
  input  logic              SHRA,
`ifdef DATAPATH_INPORT_EN
  input  logic [WORD_W-1:0] InPortData,
  input  logic              InPortStrobe,
`endif
  output logic [WORD_W-1:0] BusMuxOut,
  output logic [WORD_W-1:0] MARout,
  output logic [WORD_W-1:0] IRout
);

  // Register outputs
  logic [WORD_W-1:0] w_pc, w_ir, w_mar, w_mdr, w_y;
  logic [WORD_W-1:0] w_zlo, w_zhi;
  logic [WORD_W-1:0] w_r1, w_r2, w_r3, w_r4, w_r5, w_r7;
  logic [WORD_W-1:0] w_hi, w_lo, w_inport;

  // Bus, MDR input and ALU
  logic [WORD_W-1:0]   w_bus;
  logic [WORD_W-1:0]   w_mdr_d;
  bus_src_e            w_src;
  alu_op_e             w_op;
  logic [2*WORD_W-1:0] w_alu_res;

  // -------------------------------------------------------------------------
  // Loadable registers
  // -------------------------------------------------------------------------
  reg32 u_pc  (.i_clk(clk), .i_clr_n(clr), .i_en(PCin),  .i_d(w_bus),   .o_q(w_pc));
  reg32 u_ir  (.i_clk(clk), .i_clr_n(clr), .i_en(IRin),  .i_d(w_bus),   .o_q(w_ir));
  reg32 u_mar (.i_clk(clk), .i_clr_n(clr), .i_en(MARin), .i_d(w_bus),   .o_q(w_mar));
  reg32 u_mdr (.i_clk(clk), .i_clr_n(clr), .i_en(MDRin), .i_d(w_mdr_d), .o_q(w_mdr));
  reg32 u_y   (.i_clk(clk), .i_clr_n(clr), .i_en(Yin),   .i_d(w_bus),   .o_q(w_y));
  reg32 u_r1  (.i_clk(clk), .i_clr_n(clr), .i_en(R1in),  .i_d(w_bus),   .o_q(w_r1));
  reg32 u_r2  (.i_clk(clk), .i_clr_n(clr), .i_en(R2in),  .i_d(w_bus),   .o_q(w_r2));
  reg32 u_r3  (.i_clk(clk), .i_clr_n(clr), .i_en(R3in),  .i_d(w_bus),   .o_q(w_r3));

  // Z is the 64-bit ALU result register, split into two halves sharing Zin.
  reg32 u_zlo (.i_clk(clk), .i_clr_n(clr), .i_en(Zin),
               .i_d(w_alu_res[WORD_W-1:0]),        .o_q(w_zlo));
  reg32 u_zhi (.i_clk(clk), .i_clr_n(clr), .i_en(Zin),
               .i_d(w_alu_res[2*WORD_W-1:WORD_W]), .o_q(w_zhi));

  // -------------------------------------------------------------------------
  // Registers with no load path in this block; they stay at their reset
  // value of 0 but remain real bus sources for a later extension.
  // -------------------------------------------------------------------------
  reg32 u_r4 (.i_clk(clk), .i_clr_n(clr), .i_en(1'b0), .i_d('0), .o_q(w_r4));
  reg32 u_r5 (.i_clk(clk), .i_clr_n(clr), .i_en(1'b0), .i_d('0), .o_q(w_r5));
  reg32 u_r7 (.i_clk(clk), .i_clr_n(clr), .i_en(1'b0), .i_d('0), .o_q(w_r7));
  reg32 u_hi (.i_clk(clk), .i_clr_n(clr), .i_en(1'b0), .i_d('0), .o_q(w_hi));
  reg32 u_lo (.i_clk(clk), .i_clr_n(clr), .i_en(1'b0), .i_d('0), .o_q(w_lo));

`ifdef DATAPATH_INPORT_EN
  reg32 u_inport (.i_clk(clk), .i_clr_n(clr), .i_en(InPortStrobe),
                  .i_d(InPortData), .o_q(w_inport));
`else
  assign w_inport = '0;
`endif

  // MDR takes memory data during a read, otherwise whatever is on the bus.
  assign w_mdr_d = Read ? MDatain : w_bus;

  // -------------------------------------------------------------------------
  // Bus source priority encoder
  // -------------------------------------------------------------------------
  always_comb begin
    w_src = SRC_NONE;
    if      (PCout)     w_src = SRC_PC;
    else if (MDRout)    w_src = SRC_MDR;
    else if (Zlowout)   w_src = SRC_ZLO;
    else if (Zhighout)  w_src = SRC_ZHI;
    else if (HIout)     w_src = SRC_HI;
    else if (LOout)     w_src = SRC_LO;
    else if (InPortout) w_src = SRC_INPORT;
    else if (Cout)      w_src = SRC_C;
    else if (R2out)     w_src = SRC_R2;
    else if (R3out)     w_src = SRC_R3;
    else if (R4out)     w_src = SRC_R4;
    else if (R5out)     w_src = SRC_R5;
    else if (R7out)     w_src = SRC_R7;
  end

  // -------------------------------------------------------------------------
  // Bus multiplexer
  // -------------------------------------------------------------------------
  always_comb begin
    w_bus = '0;
    unique case (w_src)
      SRC_PC:     w_bus = w_pc;
      SRC_MDR:    w_bus = w_mdr;
      SRC_ZLO:    w_bus = w_zlo;
      SRC_ZHI:    w_bus = w_zhi;
      SRC_HI:     w_bus = w_hi;
      SRC_LO:     w_bus = w_lo;
      SRC_INPORT: w_bus = w_inport;
      SRC_C:      w_bus = sext_c(w_ir[CONST_W-1:0]);
      SRC_R2:     w_bus = w_r2;
      SRC_R3:     w_bus = w_r3;
      SRC_R4:     w_bus = w_r4;
      SRC_R5:     w_bus = w_r5;
      SRC_R7:     w_bus = w_r7;
      default:    w_bus = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // ALU: IncPC outranks SHRA; the high half of the result is always 0 for
  // the operations implemented here.
  // -------------------------------------------------------------------------
  always_comb begin
    w_op = OP_PASS;
    if (IncPC) begin
      w_op = OP_INC;
    end else if (SHRA) begin
      w_op = OP_SHRA;
    end
  end

  always_comb begin
    w_alu_res = '0;
    unique case (w_op)
      OP_INC:  w_alu_res[WORD_W-1:0] = w_bus + WORD_W'(1);
      // Only the low SHAMT_W bits of the bus form the shift amount.
      OP_SHRA: w_alu_res[WORD_W-1:0] = WORD_W'($signed(w_y) >>> w_bus[SHAMT_W-1:0]);
      default: w_alu_res[WORD_W-1:0] = w_bus;
    endcase
  end

  assign BusMuxOut = w_bus;
  assign MARout    = w_mar;
  assign IRout     = w_ir;

endmodule

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;

  logic        clk;
  logic        clr;
  logic [31:0] MDatain;
  logic        Read, PCin, IRin, MARin, MDRin, Yin, Zin, R1in, R2in, R3in;
  logic        PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout, Cout;
  logic        R2out, R3out, R4out, R5out, R7out, IncPC, SHRA;
`ifdef DATAPATH_INPORT_EN
  logic [31:0] InPortData;
  logic        InPortStrobe;
`endif
  logic [31:0] BusMuxOut, MARout, IRout;

  cpu_datapath dut (
    .clk(clk), .clr(clr), .MDatain(MDatain), .Read(Read),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .Zin(Zin), .R1in(R1in), .R2in(R2in), .R3in(R3in),
    .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .R2out(R2out), .R3out(R3out), .R4out(R4out), .R5out(R5out), .R7out(R7out),
    .IncPC(IncPC), .SHRA(SHRA),
`ifdef DATAPATH_INPORT_EN
    .InPortData(InPortData), .InPortStrobe(InPortStrobe),
`endif
    .BusMuxOut(BusMuxOut), .MARout(MARout), .IRout(IRout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word bit assignments
  localparam logic [24:0] C_READ   = 25'd1 << 0;
  localparam logic [24:0] C_PCIN   = 25'd1 << 1;
  localparam logic [24:0] C_IRIN   = 25'd1 << 2;
  localparam logic [24:0] C_MARIN  = 25'd1 << 3;
  localparam logic [24:0] C_MDRIN  = 25'd1 << 4;
  localparam logic [24:0] C_YIN    = 25'd1 << 5;
  localparam logic [24:0] C_ZIN    = 25'd1 << 6;
  localparam logic [24:0] C_R1IN   = 25'd1 << 7;
  localparam logic [24:0] C_R2IN   = 25'd1 << 8;
  localparam logic [24:0] C_R3IN   = 25'd1 << 9;
  localparam logic [24:0] C_PCOUT  = 25'd1 << 10;
  localparam logic [24:0] C_MDROUT = 25'd1 << 11;
  localparam logic [24:0] C_ZLOOUT = 25'd1 << 12;
  localparam logic [24:0] C_ZHIOUT = 25'd1 << 13;
  localparam logic [24:0] C_HIOUT  = 25'd1 << 14;
  localparam logic [24:0] C_LOOUT  = 25'd1 << 15;
  localparam logic [24:0] C_INOUT  = 25'd1 << 16;
  localparam logic [24:0] C_COUT   = 25'd1 << 17;
  localparam logic [24:0] C_R2OUT  = 25'd1 << 18;
  localparam logic [24:0] C_R3OUT  = 25'd1 << 19;
  localparam logic [24:0] C_R4OUT  = 25'd1 << 20;
  localparam logic [24:0] C_R5OUT  = 25'd1 << 21;
  localparam logic [24:0] C_R7OUT  = 25'd1 << 22;
  localparam logic [24:0] C_INC    = 25'd1 << 23;
  localparam logic [24:0] C_SHRA   = 25'd1 << 24;

  // What to inspect after the capturing edge
  localparam int K_NONE = 0, K_MAR = 1, K_IR = 2, K_ZLO = 3, K_R1 = 4, K_PC = 5, K_Y = 6;

  typedef struct {
    string       name;
    logic [24:0] ctrl;
    logic [31:0] mdat;
    logic [31:0] exp_bus;
    int          kind;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input string n, input logic [24:0] c, input logic [31:0] m,
                     input logic [31:0] eb, input int k, input logic [31:0] ev);
    vec_t v;
    v.name = n; v.ctrl = c; v.mdat = m; v.exp_bus = eb; v.kind = k; v.exp_val = ev;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic [24:0] c, input logic [31:0] m);
    MDatain   = m;
    Read      = c[0];  PCin     = c[1];  IRin    = c[2];  MARin   = c[3];
    MDRin     = c[4];  Yin      = c[5];  Zin     = c[6];  R1in    = c[7];
    R2in      = c[8];  R3in     = c[9];  PCout   = c[10]; MDRout  = c[11];
    Zlowout   = c[12]; Zhighout = c[13]; HIout   = c[14]; LOout   = c[15];
    InPortout = c[16]; Cout     = c[17]; R2out   = c[18]; R3out   = c[19];
    R4out     = c[20]; R5out    = c[21]; R7out   = c[22]; IncPC   = c[23];
    SHRA      = c[24];
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    drive(v.ctrl, v.mdat);
    #3;  // bus sampled well before the capturing falling edge
    check({v.name, " bus"}, BusMuxOut, v.exp_bus);
    $display("vec %-14s ctrl=%07h mdat=%08h bus=%08h", v.name, v.ctrl, v.mdat, BusMuxOut);
    @(negedge clk); #1;
    case (v.kind)
      K_MAR: check({v.name, " MAR"}, MARout, v.exp_val);
      K_IR:  check({v.name, " IR"}, IRout, v.exp_val);
      K_ZLO: begin
        check({v.name, " Zlo"}, dut.w_zlo, v.exp_val);
        check({v.name, " Zhi"}, dut.w_zhi, 32'h0);
      end
      K_R1:  check({v.name, " R1"}, dut.w_r1, v.exp_val);
      K_PC:  check({v.name, " PC"}, dut.w_pc, v.exp_val);
      K_Y:   check({v.name, " Y"}, dut.w_y, v.exp_val);
      default: ;
    endcase
  endtask

  initial begin
`ifdef DATAPATH_INPORT_EN
    InPortData = 32'h0; InPortStrobe = 1'b0;
`endif
    clr = 1'b0;
    drive('0, 32'h0);

    // ---- Reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("reset bus", BusMuxOut, 32'h0);
    check("reset MAR", MARout, 32'h0);
    check("reset IR", IRout, 32'h0);
    clr = 1'b1;

    // ---- Vector table ----
    add("idle",        '0,                         32'h0,        32'h0,        K_MAR, 32'h0);
    add("ld_mdr_db",   C_READ | C_MDRIN,           32'hDB,       32'h0,        K_NONE, 32'h0);
    add("mdr_to_r2",   C_MDROUT | C_R2IN,          32'h0,        32'hDB,       K_NONE, 32'h0);
    add("r2_to_y",     C_R2OUT | C_YIN,            32'h0,        32'hDB,       K_Y,   32'hDB);
    add("ld_mdr_2",    C_READ | C_MDRIN,           32'h2,        32'h0,        K_NONE, 32'h0);
    add("mdr_to_r3",   C_MDROUT | C_R3IN,          32'h0,        32'h2,        K_NONE, 32'h0);
    add("shra_pos",    C_R3OUT | C_SHRA | C_ZIN,   32'h0,        32'h2,        K_ZLO, 32'h36);
    add("z_to_r1",     C_ZLOOUT | C_R1IN | C_MARIN, 32'h0,       32'h36,       K_R1,  32'h36);
    add("mar_36",      '0,                         32'h0,        32'h0,        K_MAR, 32'h36);
    add("ld_mdr_neg",  C_READ | C_MDRIN,           32'h80000000, 32'h0,        K_NONE, 32'h0);
    add("mdr_to_y",    C_MDROUT | C_YIN,           32'h0,        32'h80000000, K_Y,   32'h80000000);
    add("ld_mdr_31",   C_READ | C_MDRIN,           32'd31,       32'h0,        K_NONE, 32'h0);
    add("shra_31",     C_MDROUT | C_SHRA | C_ZIN,  32'h0,        32'd31,       K_ZLO, 32'hFFFFFFFF);
    add("ld_mdr_22",   C_READ | C_MDRIN,           32'h22,       32'h0,        K_NONE, 32'h0);
    add("shra_22",     C_MDROUT | C_SHRA | C_ZIN,  32'h0,        32'h22,       K_ZLO, 32'hE0000000);
    add("zhigh_out",   C_ZHIOUT,                   32'h0,        32'h0,        K_NONE, 32'h0);
    add("fetch1",      C_PCOUT | C_MARIN | C_INC | C_ZIN, 32'h0, 32'h0,        K_ZLO, 32'h1);
    add("fetch1_mar",  '0,                         32'h0,        32'h0,        K_MAR, 32'h0);
    add("fetch2",      C_ZLOOUT | C_PCIN | C_READ | C_MDRIN, 32'h28918000, 32'h1, K_PC, 32'h1);
    add("fetch3",      C_MDROUT | C_IRIN,          32'h0,        32'h28918000, K_IR,  32'h28918000);
    add("prio_pc_r2",  C_PCOUT | C_R2OUT,          32'h0,        32'h1,        K_NONE, 32'h0);
    add("cout_pos",    C_COUT,                     32'h0,        32'h00018000, K_NONE, 32'h0);
    add("prio_mdr_z",  C_MDROUT | C_ZLOOUT,        32'h0,        32'h28918000, K_NONE, 32'h0);
    add("ld_mdr_c",    C_READ | C_MDRIN,           32'h00040000, 32'h0,        K_NONE, 32'h0);
    add("mdr_to_ir",   C_MDROUT | C_IRIN,          32'h0,        32'h00040000, K_IR,  32'h00040000);
    add("cout_neg",    C_COUT | C_R2OUT,           32'h0,        32'hFFFC0000, K_NONE, 32'h0);
    add("ld_mdr_ff",   C_READ | C_MDRIN,           32'hFFFFFFFF, 32'h0,        K_NONE, 32'h0);
    add("mdr_to_pc",   C_MDROUT | C_PCIN,          32'h0,        32'hFFFFFFFF, K_PC,  32'hFFFFFFFF);
    add("inc_wrap",    C_PCOUT | C_INC | C_SHRA | C_ZIN, 32'h0,  32'hFFFFFFFF, K_ZLO, 32'h0);
    add("zlo_wrap",    C_ZLOOUT,                   32'h0,        32'h0,        K_NONE, 32'h0);
    add("pc_self",     C_PCOUT | C_PCIN,           32'h0,        32'hFFFFFFFF, K_PC,  32'hFFFFFFFF);
    add("r2_to_mdr",   C_R2OUT | C_MDRIN,          32'h12345678, 32'hDB,       K_NONE, 32'h0);
    add("mdr_bus_path", C_MDROUT | C_ZIN,          32'h0,        32'hDB,       K_ZLO, 32'hDB);
    add("null_srcs",   C_HIOUT | C_LOOUT | C_INOUT | C_R4OUT | C_R5OUT | C_R7OUT,
                                                   32'h0,        32'h0,        K_NONE, 32'h0);
    add("r3_out",      C_R3OUT,                    32'h0,        32'h2,        K_NONE, 32'h0);
    add("pc_to_mar",   C_PCOUT | C_MARIN,          32'h0,        32'hFFFFFFFF, K_MAR, 32'hFFFFFFFF);

    foreach (vecs[i]) run_vec(vecs[i]);

    // ---- Asynchronous reset in the middle of a transfer ----
    @(posedge clk); #1;
    drive(C_PCOUT, 32'h0);
    #1;
    check("pre_reset bus", BusMuxOut, 32'hFFFFFFFF);
    clr = 1'b0;
    #1;  // still before the falling edge: clear must not wait for the clock
    check("async_rst bus", BusMuxOut, 32'h0);
    check("async_rst MAR", MARout, 32'h0);
    check("async_rst IR", IRout, 32'h0);
    $display("seq async_reset bus=%08h mar=%08h ir=%08h", BusMuxOut, MARout, IRout);
    @(posedge clk); #1;
    clr = 1'b1;
    drive(C_MDROUT, 32'h0);
    #2;
    check("post_rst MDR", BusMuxOut, 32'h0);
    drive(C_R2OUT, 32'h0);
    #1;
    check("post_rst R2", BusMuxOut, 32'h0);
    @(negedge clk); #1;
    check("post_rst Zlo", dut.w_zlo, 32'h0);
    $display("seq post_reset r2_bus=%08h", BusMuxOut);

    // ---- Restarted fetch after reset ----
    run_vec('{"refetch", C_PCOUT | C_MARIN | C_INC | C_ZIN, 32'h0, 32'h0, K_ZLO, 32'h1});
    run_vec('{"refetch_pc", C_ZLOOUT | C_PCIN, 32'h0, 32'h1, K_PC, 32'h1});
    drive('0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

32-bit single-bus CPU datapath driven one control word per clock by an external control unit or testbench. Holds PC, IR, MAR, MDR, Y, the 64-bit Z result register, HI/LO, and general registers R1–R7. Contains an ALU that supports PC increment and arithmetic shift right. All transfers between these elements go over one shared internal bus.

## Interface
Parameters:
- none (data width fixed at 32 via package constant)

Ports:
- clk  in  1  system clock; all registers capture on the falling edge
- clr  in  1  asynchronous, active-low reset
- MDatain  in  32  memory read data
- Read  in  1  MDR input mux select: 1 selects MDatain, 0 selects the bus
- PCin, IRin, MARin, MDRin, Yin, Zin, R1in, R2in, R3in  in  1 each  register load enables
- PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout, Cout, R2out, R3out, R4out, R5out, R7out  in  1 each  bus source selects
- IncPC  in  1  ALU op: Z = bus + 1
- SHRA  in  1  ALU op: Z = Y >>> bus[4:0]
- BusMuxOut  out  32  current bus value
- MARout  out  32  MAR contents (memory address)
- IRout  out  32  IR contents

## Operation
- Bus source select is by fixed priority, highest first: PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout, Cout, R2out, R3out, R4out, R5out, R7out.
- If no out signal is high, the bus is 0.
- Cout drives the sign-extended IR[18:0].
- MDR D-input is MDatain when Read=1, otherwise the bus. MDR loads only when MDRin=1.
- PC, IR, MAR, Y, R1, R2 and R3 load from the bus when their enable is high.
- R4, R5, R7, HI, LO and the in-port register have no load path in this block. They hold 0.
- ALU result is captured into Z when Zin=1:
  - IncPC=1 (takes priority over SHRA): Zlow = bus + 1, wraps at 32 bits; Zhigh = 0.
  - SHRA=1: Zlow = arithmetic shift right of Y by bus[4:0], sign bit replicated; Zhigh = 0.
  - Neither: Zlow = bus; Zhigh = 0.
- Shift amount uses bus[4:0] only; upper bits are ignored. A shift of 31 on a negative Y gives 0xFFFFFFFF.

## Timing
- Reset (clr=0, asynchronous) clears every register to 0. BusMuxOut, MARout and IRout are therefore 0 while in reset.
- Control signals are asserted after a rising edge and must be stable by the following falling edge, where the capture happens.
- Each register transfer takes one cycle. The bus is combinational within the cycle.
- Result visibility:
  - Z result is usable on the bus (via Zlowout) in the cycle after Zin.
  - An operand loaded into Y is usable by the ALU in the next cycle.
- A simultaneous Xout and Xin for the same register reloads that register with its old value.
- Reset asserted mid-sequence clears state immediately. The sequence must be restarted.

## Configuration
- DATAPATH_INPORT_EN defined:
  - adds input InPortData (32).
  - adds input InPortStrobe (1); the in-port register loads InPortData on the falling edge when InPortStrobe=1.
  - InPortout drives this register onto the bus.
- DATAPATH_INPORT_EN undefined: the in-port register is absent and InPortout drives 0.

## Structure
- Package datapath_pkg:
  - WORD_W = 32 and SHAMT_W = 5.
  - the bus-source priority enumeration.
  - the ALU op typedef (OP_PASS, OP_INC, OP_SHRA).
- Sub-module reg32: 32-bit register with enable, falling-edge capture and async active-low clear. Instantiate it for every register; Z is two instances.
- The ALU and the bus mux are combinational blocks inside cpu_datapath.

## Test plan
- Reset: clr=0 mid-run → all registers and outputs become 0 immediately; BusMuxOut=0 while no out signal is asserted.
- Register load: MDatain=0xDB with Read=1, MDRin=1; next cycle MDRout=1, R2in=1 → R2=0x000000DB. Then R2out=1 → BusMuxOut=0xDB.
- Shift positive value: R2=0xDB, R3=2; R2out+Yin; then R3out+SHRA+Zin; then Zlowout+R1in → R1=0x36, Zhigh=0.
- Shift negative value: Y=0x80000000, shift amount 31 → Zlow=0xFFFFFFFF. Shift amount 0x22 (uses bits [4:0]=2) → Zlow=0xE0000000.
- Fetch: PC=0; PCout+MARin+IncPC+Zin → MAR=0, Zlow=1. Zlowout+PCin+Read+MDRin with MDatain=0x28918000 → PC=1. MDRout+IRin → IRout=0x28918000.
- Priority and wrap:
  - PCout and R2out both high → bus = PC.
  - PC=0xFFFFFFFF with IncPC → Zlow=0.
  - Cout with IR[18:0]=0x40000 → bus=0xFFFC0000.
